// File: rtl/atm_account_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atm_pkg
// Description : Shared definitions for the ATM account arbiter slice: FSM
//               state encoding, transaction op codes and default balance.
// Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic OP_DEPOSIT  = 1'b0;
  localparam logic OP_WITHDRAW = 1'b1;

  localparam logic [63:0] DEFAULT_INIT_BALANCE = 64'd4500;

endpackage
`default_nettype wire

// File: rtl/atm_account_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : atm_account_arbiter_if
// Description : Request/response bundle between the ATM front-end
//               controllers (master) and the account arbiter (slave).
//   req      N_PORTS        per-port level request, held until ack
//   op       N_PORTS        per-port op, 1 = withdraw, 0 = deposit
//   amount   N_PORTS*AMT_W  per-port amount, port i at [i*AMT_W +: AMT_W]
//   ack      N_PORTS        one-cycle completion pulse to the served port
//   ok/insufficient/overflow  status, valid while ack is high
//   balance  BAL_W          current balance
//   busy     1              arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface atm_account_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int AMT_W   = 32,
  parameter int BAL_W   = 64
) ();

  logic [N_PORTS-1:0]       req;
  logic [N_PORTS-1:0]       op;
  logic [N_PORTS*AMT_W-1:0] amount;
  logic [N_PORTS-1:0]       ack;
  logic                     ok;
  logic                     insufficient;
  logic                     overflow;
  logic [BAL_W-1:0]         balance;
  logic                     busy;

  modport master (
    output req, op, amount,
    input  ack, ok, insufficient, overflow, balance, busy
  );

  modport slave (
    input  req, op, amount,
    output ack, ok, insufficient, overflow, balance, busy
  );

endinterface
`default_nettype wire

// File: rtl/atm_account_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Returns the first set
//               request bit scanning ptr, ptr+1, ... modulo N_PORTS.
//   req_i     N_PORTS  request vector
//   ptr_i     IDX_W    highest-priority index
//   winner_o  IDX_W    selected index (valid only with valid_o)
//   valid_o   1        any request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  logic [2*N_PORTS-1:0] w_req2;
  logic [N_PORTS-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;

  // Rotate so that bit 0 of w_rot corresponds to port ptr_i.
  assign w_req2 = {req_i, req_i};
  assign w_rot  = w_req2[N_PORTS-1:0] >> ptr_i | w_req2[2*N_PORTS-1:N_PORTS] << (IDX_W'(N_PORTS) - ptr_i);

  // Lowest set bit of the rotated vector; scanning downward lets the
  // smallest offset overwrite the larger ones.
  always_comb begin
    w_off = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
  end

  assign w_sum    = {1'b0, ptr_i} + {1'b0, w_off};
  assign winner_o = (w_sum >= (IDX_W + 1)'(N_PORTS)) ?
                    IDX_W'(w_sum - (IDX_W + 1)'(N_PORTS)) : w_sum[IDX_W-1:0];
  assign valid_o  = |req_i;

endmodule
`default_nettype wire

// File: rtl/atm_account_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : atm_account_arbiter
// Description : Round-robin arbiter that serialises deposit/withdraw
//               transactions from N_PORTS ATM controllers onto a single
//               balance register and reports per-transaction status.
//   clk     1  clock, rising edge
//   rst     1  synchronous active-high reset
//   bus_io  atm_account_arbiter_if.slave  request/status bundle
// Revision    : 1.0 - initial release
// ============================================================================
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int               N_PORTS      = 4,
  parameter int               AMT_W        = 32,
  parameter int               BAL_W        = 64,
  parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(DEFAULT_INIT_BALANCE)
) (
  input  logic                 clk,
  input  logic                 rst,
  atm_account_arbiter_if.slave bus_io
);

  localparam int IDX_W = $clog2(N_PORTS);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               op_q, op_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic               ok_q, ok_d;
  logic               insuf_q, insuf_d;
  logic               ovf_q, ovf_d;

  logic [IDX_W-1:0]   w_pick_win;
  logic               w_pick_valid;
  logic [AMT_W-1:0]   w_pick_amt;
  logic               w_pick_op;
  logic [BAL_W-1:0]   w_amt_ext;
  logic [BAL_W:0]     w_sum;

  rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (bus_io.req),
    .ptr_i    (ptr_q),
    .winner_o (w_pick_win),
    .valid_o  (w_pick_valid)
  );

  // Mux the winner's fields out of the flat request vectors.
  always_comb begin
    w_pick_amt = '0;
    w_pick_op  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_pick_win == IDX_W'(i)) begin
        w_pick_amt = bus_io.amount[i*AMT_W +: AMT_W];
        w_pick_op  = bus_io.op[i];
      end
    end
  end

  // One extra bit catches deposit carry-out as overflow.
  assign w_amt_ext = BAL_W'(amt_q);
  assign w_sum     = {1'b0, bal_q} + {1'b0, w_amt_ext};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_DEPOSIT;
      amt_q   <= '0;
      bal_q   <= INIT_BALANCE;
      ok_q    <= 1'b0;
      insuf_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      bal_q   <= bal_d;
      ok_q    <= ok_d;
      insuf_q <= insuf_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    amt_d   = amt_q;
    bal_d   = bal_q;
    ok_d    = ok_q;
    insuf_d = insuf_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (w_pick_valid) begin
          win_d   = w_pick_win;
          op_d    = w_pick_op;
          amt_d   = w_pick_amt;
          ptr_d   = (w_pick_win == IDX_W'(N_PORTS - 1)) ? '0 : w_pick_win + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        ok_d    = 1'b0;
        insuf_d = 1'b0;
        ovf_d   = 1'b0;
        if (op_q == OP_WITHDRAW) begin
          if (w_amt_ext <= bal_q) begin
            bal_d = bal_q - w_amt_ext;
            ok_d  = 1'b1;
          end else begin
            insuf_d = 1'b1;
          end
        end else begin
          if (w_sum[BAL_W]) begin
            ovf_d = 1'b1;
          end else begin
            bal_d = w_sum[BAL_W-1:0];
            ok_d  = 1'b1;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        ok_d    = 1'b0;
        insuf_d = 1'b0;
        ovf_d   = 1'b0;
        state_d = RELEASE;
      end
      RELEASE: begin
        // Hold here until the served port drops its request so a
        // still-asserted level request is not granted twice.
        if (!bus_io.req[win_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.ack          = (state_q == RESP) ?
                               ({{(N_PORTS-1){1'b0}}, 1'b1} << win_q) : '0;
  assign bus_io.ok           = ok_q;
  assign bus_io.insufficient = insuf_q;
  assign bus_io.overflow     = ovf_q;
  assign bus_io.balance      = bal_q;
  assign bus_io.busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_atm_account_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_atm_account_arbiter
// Description : Directed self-checking bench for atm_account_arbiter.
//               A second instance starts near the top of the balance range
//               to exercise deposit overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_account_arbiter;
  import atm_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 64;
  localparam logic [BW-1:0] NEAR_MAX = 64'hFFFF_FFFF_FFFF_FFF6;
  localparam logic [BW-1:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_account_arbiter_if #(.N_PORTS(N), .AMT_W(AW), .BAL_W(BW)) bus ();
  atm_account_arbiter_if #(.N_PORTS(N), .AMT_W(AW), .BAL_W(BW)) bus2 ();

  atm_account_arbiter #(.N_PORTS(N), .AMT_W(AW), .BAL_W(BW), .INIT_BALANCE(64'd4500)) dut (
    .clk(clk), .rst(rst), .bus_io(bus)
  );

  atm_account_arbiter #(.N_PORTS(N), .AMT_W(AW), .BAL_W(BW), .INIT_BALANCE(NEAR_MAX)) dut2 (
    .clk(clk), .rst(rst), .bus_io(bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;  bus.op = '0;  bus.amount = '0;
    bus2.req = '0; bus2.op = '0; bus2.amount = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request and reports what came back; lat = negedges to ack, -1 on timeout.
  task automatic single_txn(input bit sel, input int port, input logic op, input logic [AW-1:0] amt,
                            output logic [N-1:0] ack_s, output logic [2:0] flags_s,
                            output logic [BW-1:0] bal_s, output int lat);
    logic [N-1:0] cur;
    lat = -1; ack_s = '0; flags_s = '0; bal_s = '0;
    if (sel) begin
      bus2.op[port] = op; bus2.amount[port*AW +: AW] = amt; bus2.req[port] = 1'b1;
    end else begin
      bus.op[port] = op;  bus.amount[port*AW +: AW] = amt;  bus.req[port] = 1'b1;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cur = sel ? bus2.ack : bus.ack;
      if (cur != '0) begin
        lat   = c;
        ack_s = cur;
        flags_s = sel ? {bus2.ok, bus2.insufficient, bus2.overflow}
                      : {bus.ok, bus.insufficient, bus.overflow};
        bal_s = sel ? bus2.balance : bus.balance;
        break;
      end
    end
    if (sel) bus2.req[port] = 1'b0; else bus.req[port] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(sel ? bus2.busy : bus.busy)) break;
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] acc;
    do_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (bus.balance !== 64'd4500) begin n_fail++; $display("FAIL reset_balance: got %0d expected 4500", bus.balance); end
    n_checks++; if (bus.ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if ({bus.ok, bus.insufficient, bus.overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.ok, bus.insufficient, bus.overflow}); end
    n_checks++; if (bus2.balance !== NEAR_MAX) begin n_fail++; $display("FAIL reset_balance2: got %0h expected %0h", bus2.balance, NEAR_MAX); end
    // Reset lands while a withdraw of 100 sits in EXEC.
    bus.op[0] = OP_WITHDRAW; bus.amount[0 +: AW] = 32'd100; bus.req[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_exec_busy: got %b expected 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0) begin n_fail++; $display("FAIL midrst_abort: got busy=%b ack=%b expected busy=0 ack=0000", bus.busy, bus.ack); end
    bus.req[0] = 1'b0; rst = 1'b0;
    acc = '0;
    repeat (4) begin @(negedge clk); acc |= bus.ack; end
    n_checks++; if (acc !== 4'b0) begin n_fail++; $display("FAIL midrst_no_ack: got %b expected 0000", acc); end
    n_checks++; if (bus.balance !== 64'd4500) begin n_fail++; $display("FAIL midrst_balance: got %0d expected 4500", bus.balance); end
  endtask

  task automatic test_deposit_hold();
    logic [N-1:0] acc;
    bus.op[0] = OP_DEPOSIT; bus.amount[0 +: AW] = 32'd1000; bus.req[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL dep_exec: got ack=%b busy=%b expected ack=0000 busy=1", bus.ack, bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL dep_ack: got %b expected 0001", bus.ack); end
    n_checks++; if ({bus.ok, bus.insufficient, bus.overflow} !== 3'b100) begin n_fail++; $display("FAIL dep_flags: got %b expected 100", {bus.ok, bus.insufficient, bus.overflow}); end
    n_checks++; if (bus.balance !== 64'd5500) begin n_fail++; $display("FAIL dep_balance: got %0d expected 5500", bus.balance); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0 || {bus.ok, bus.insufficient, bus.overflow} !== 3'b000) begin n_fail++; $display("FAIL dep_release_clear: got ack=%b flags=%b expected 0000/000", bus.ack, {bus.ok, bus.insufficient, bus.overflow}); end
    @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL dep_hold_wait: got ack=%b busy=%b expected 0000/1", bus.ack, bus.busy); end
    bus.req[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dep_back_idle: got busy=%b expected 0", bus.busy); end
    acc = '0;
    repeat (3) begin @(negedge clk); acc |= bus.ack; end
    n_checks++; if (acc !== 4'b0 || bus.balance !== 64'd5500) begin n_fail++; $display("FAIL dep_no_double: got ack=%b bal=%0d expected 0000/5500", acc, bus.balance); end
  endtask

  task automatic test_withdraw();
    logic [N-1:0] a; logic [2:0] f; logic [BW-1:0] b; int lat;
    do_reset();
    single_txn(1'b0, 1, OP_WITHDRAW, 32'd6000, a, f, b, lat);
    n_checks++; if (lat != 2 || a !== 4'b0010) begin n_fail++; $display("FAIL wd_insuf_ack: got lat=%0d ack=%b expected 2/0010", lat, a); end
    n_checks++; if (f !== 3'b010 || b !== 64'd4500) begin n_fail++; $display("FAIL wd_insuf: got flags=%b bal=%0d expected 010/4500", f, b); end
    single_txn(1'b0, 1, OP_WITHDRAW, 32'd4500, a, f, b, lat);
    n_checks++; if (a !== 4'b0010 || f !== 3'b100 || b !== 64'd0) begin n_fail++; $display("FAIL wd_equal: got ack=%b flags=%b bal=%0d expected 0010/100/0", a, f, b); end
    single_txn(1'b0, 1, OP_WITHDRAW, 32'd0, a, f, b, lat);
    n_checks++; if (f !== 3'b100 || b !== 64'd0) begin n_fail++; $display("FAIL wd_zero: got flags=%b bal=%0d expected 100/0", f, b); end
    single_txn(1'b0, 2, OP_DEPOSIT, 32'd0, a, f, b, lat);
    n_checks++; if (a !== 4'b0100 || f !== 3'b100 || b !== 64'd0) begin n_fail++; $display("FAIL dep_zero: got ack=%b flags=%b bal=%0d expected 0100/100/0", a, f, b); end
    single_txn(1'b0, 1, OP_WITHDRAW, 32'd1, a, f, b, lat);
    n_checks++; if (f !== 3'b010 || b !== 64'd0) begin n_fail++; $display("FAIL wd_from_zero: got flags=%b bal=%0d expected 010/0", f, b); end
  endtask

  task automatic run_burst(input logic [N-1:0] mask, input int exp_n, input int exp0, input int exp1,
                           input int exp2, input int exp3, input logic [BW-1:0] exp_bal, input string nm);
    int order[4]; int cnt; int idx;
    cnt = 0;
    for (int i = 0; i < N; i++) order[i] = -1;
    for (int i = 0; i < N; i++) if (mask[i]) begin
      bus.op[i] = OP_WITHDRAW; bus.amount[i*AW +: AW] = 32'd10;
    end
    bus.req = mask;
    for (int c = 0; c < 60 && cnt < exp_n; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        n_checks++; if (!$onehot(bus.ack)) begin n_fail++; $display("FAIL %s_onehot: got %b expected one bit", nm, bus.ack); end
        idx = -1;
        for (int j = 0; j < N; j++) if (bus.ack[j]) idx = j;
        if (cnt < 4) order[cnt] = idx;
        cnt++;
        if (idx >= 0) bus.req[idx] = 1'b0;
      end
    end
    bus.req = '0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (!bus.busy) break; end
    n_checks++; if (cnt != exp_n) begin n_fail++; $display("FAIL %s_count: got %0d expected %0d", nm, cnt, exp_n); end
    n_checks++; if (order[0] != exp0 || order[1] != exp1 || order[2] != exp2 || order[3] != exp3) begin
      n_fail++; $display("FAIL %s_order: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d", nm,
                         order[0], order[1], order[2], order[3], exp0, exp1, exp2, exp3);
    end
    n_checks++; if (bus.balance !== exp_bal) begin n_fail++; $display("FAIL %s_balance: got %0d expected %0d", nm, bus.balance, exp_bal); end
  endtask

  task automatic test_rr_burst();
    do_reset();
    run_burst(4'b1111, 4, 0, 1, 2, 3, 64'd4460, "burst_all");
    run_burst(4'b1010, 2, 1, 3, -1, -1, 64'd4440, "burst_13");
  endtask

  task automatic test_latched_amount();
    bus.op[2] = OP_WITHDRAW; bus.amount[2*AW +: AW] = 32'd100; bus.req[2] = 1'b1;
    @(negedge clk);
    bus.amount[2*AW +: AW] = 32'd900;
    bus.op[2] = OP_DEPOSIT;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack != '0) break;
    end
    n_checks++; if (bus.ack !== 4'b0100 || bus.ok !== 1'b1) begin n_fail++; $display("FAIL latch_ack: got ack=%b ok=%b expected 0100/1", bus.ack, bus.ok); end
    n_checks++; if (bus.balance !== 64'd4340) begin n_fail++; $display("FAIL latch_balance: got %0d expected 4340", bus.balance); end
    bus.req[2] = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (!bus.busy) break; end
  endtask

  task automatic test_overflow();
    logic [N-1:0] a; logic [2:0] f; logic [BW-1:0] b; int lat;
    single_txn(1'b1, 3, OP_DEPOSIT, 32'd20, a, f, b, lat);
    n_checks++; if (lat != 2 || a !== 4'b1000 || f !== 3'b001 || b !== NEAR_MAX) begin n_fail++; $display("FAIL ovf_20: got lat=%0d ack=%b flags=%b bal=%0h expected 2/1000/001/%0h", lat, a, f, b, NEAR_MAX); end
    single_txn(1'b1, 3, OP_DEPOSIT, 32'd9, a, f, b, lat);
    n_checks++; if (f !== 3'b100 || b !== ALL_ONES) begin n_fail++; $display("FAIL ovf_fit_max: got flags=%b bal=%0h expected 100/%0h", f, b, ALL_ONES); end
    single_txn(1'b1, 0, OP_DEPOSIT, 32'd1, a, f, b, lat);
    n_checks++; if (a !== 4'b0001 || f !== 3'b001 || b !== ALL_ONES) begin n_fail++; $display("FAIL ovf_by_one: got ack=%b flags=%b bal=%0h expected 0001/001/%0h", a, f, b, ALL_ONES); end
    single_txn(1'b1, 1, OP_WITHDRAW, 32'hFFFF_FFFF, a, f, b, lat);
    n_checks++; if (f !== 3'b100 || b !== 64'hFFFF_FFFF_0000_0000) begin n_fail++; $display("FAIL wd_wide: got flags=%b bal=%0h expected 100/ffffffff00000000", f, b); end
  endtask

  initial begin
    test_reset();
    test_deposit_hold();
    test_withdraw();
    test_rr_burst();
    test_latched_amount();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/atm_account_arbiter.md
Name: atm_account_arbiter

Overview:
Shares one account balance register among N_PORTS ATM front-end controllers. Requesters issue deposit or withdraw transactions over a level req/ack handshake. The block grants one requester at a time using round-robin priority, applies the arithmetic atomically, and returns per-port status. It sits between the per-terminal ATM controllers and the account store, and is the only writer of the balance.

Parameters:
N_PORTS, 4, number of requesting controllers (2..8)
AMT_W, 32, width of a transaction amount
BAL_W, 64, width of the balance register
INIT_BALANCE, 4500, balance loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
req  in  N_PORTS  per-port request, level, held until ack
op  in  N_PORTS  per-port op: 1 = withdraw, 0 = deposit
amount  in  N_PORTS*AMT_W  per-port amount, port i at [i*AMT_W +: AMT_W]
ack  out  N_PORTS  one-cycle completion pulse to the served port
ok  out  1  transaction applied; valid only while any ack bit is high
insufficient  out  1  withdraw rejected because amount > balance; valid with ack
overflow  out  1  deposit rejected because the result would exceed 2^BAL_W-1; valid with ack
balance  out  BAL_W  current balance (registered)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE, balance=INIT_BALANCE, ptr=0, ack=0, ok=0, insufficient=0, overflow=0, busy=0.
- Reset has priority over everything, including mid-transaction. Any in-flight transaction is discarded and no ack is issued.
- FSM states: IDLE, EXEC, RESP, RELEASE.
- IDLE, when any req bit is high:
  - Pick winner w = first set bit scanning ptr, ptr+1, ... modulo N_PORTS.
  - Latch w, op[w] and amount[w].
  - Set ptr <= (w+1) mod N_PORTS.
  - Go to EXEC.
- EXEC, deposit:
  - If balance + amount fits in BAL_W: balance <= balance + amount, ok=1.
  - Otherwise: balance unchanged, overflow=1.
- EXEC, withdraw:
  - If amount <= balance: balance <= balance - amount, ok=1. Equal amounts give balance 0.
  - Otherwise: balance unchanged, insufficient=1.
  - Comparison is unsigned, with amount zero-extended to BAL_W.
- EXEC always goes to RESP. Status flags are registered, so they appear in RESP.
- RESP:
  - ack[w]=1 for exactly one cycle; ok/insufficient/overflow are held alongside it.
  - Exactly one of ok/insufficient/overflow is high.
  - Go to RELEASE.
- RELEASE:
  - ack and flags return to 0.
  - Wait until req[w]==0, then go to IDLE. This prevents double service of a held request.
- Latency: req seen in IDLE at cycle t, then EXEC at t+1, ack at t+2, balance updated and visible at t+2. Minimum turnaround per transaction is 4 cycles.
- Transaction fields are latched in IDLE. Changes to op or amount after the grant are ignored.
- Requests from other ports are held pending, never dropped. Those ports receive service in round-robin order on later IDLE visits.
- Amount 0: a deposit or a withdraw is accepted with ok=1 and the balance unchanged.
- Only one ack bit is ever high at a time.
- ack is never asserted outside RESP.

Decomposition:
- Shared package atm_pkg holds:
  - the state encoding: IDLE=0, EXEC=1, RESP=2, RELEASE=3
  - the op constants OP_DEPOSIT=0 and OP_WITHDRAW=1
  - the default INIT_BALANCE
- Sub-module rr_picker (combinational):
  - inputs: req vector and ptr
  - outputs: winner index and a valid flag
  - reused by later arbiters, such as the cash-cassette sharing block.
- Everything else (FSM, latches, balance arithmetic) stays in atm_account_arbiter.

Test Plan:
- Reset, then idle 5 cycles -> balance=4500, ack=0, busy=0. Assert rst during EXEC of a withdraw of 100 -> no ack, balance=4500.
- Port0 deposits 1000 at cycle t -> ack[0] at t+2 with ok=1, balance=5500. Hold req until t+4 -> no second ack.
- Port1 withdraws 6000 from 4500 -> ack[1] with insufficient=1, ok=0, balance stays 4500. Then withdraws 4500 -> ok=1, balance=0.
- All 4 ports request withdraw 10 simultaneously and each drops req after its ack -> acks in order 0,1,2,3; final balance 4460. A second burst with only ports 1 and 3 requesting, from ptr=0 -> order 1 then 3.
- Port2 changes amount from 100 to 900 one cycle after grant -> balance decreases by 100 only.
- Force balance to 2^64-10, then port3 deposits 20 -> overflow=1, balance unchanged.
